// File: rtl/uart_cmd_responder_if.sv
// FIFO-side handshake bundle between the command responder and the UART
// receive/transmit FIFOs.
interface uart_cmd_responder_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] r_data;
  logic            rx_empty;
  logic            rd_uart;
  logic [DBIT-1:0] w_data;
  logic            wr_uart;
  logic            tx_full;

  modport master (
    input  r_data, rx_empty, tx_full,
    output rd_uart, w_data, wr_uart
  );

  modport slave (
    output r_data, rx_empty, tx_full,
    input  rd_uart, w_data, wr_uart
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// Byte-oriented command responder: 'W' addr data writes a 16x8 register file,
// 'R' addr reads it back, anything else is answered with '?'.
module uart_cmd_responder #(
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_cmd_responder_if.master   uif,
  output logic [7:0]             ctrl_reg,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RESP_OK  = 8'h4B;
  localparam logic [7:0] RESP_BAD = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    SEND
  } state_t;

  state_t          state_q, state_d;
  logic            is_rd_q, is_rd_d;
  logic [3:0]      addr_q, addr_d;
  logic [7:0]      resp_q, resp_d;
  logic [7:0]      err_q, err_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [7:0]      regs_q [16];
  logic [7:0]      regs_d [16];
  logic            pop;
  logic            push;
  logic [7:0]      rx_byte;
  logic            expired;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rx_byte = uif.r_data[7:0];
  assign expired = (tmo_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    resp_d  = resp_q;
    err_d   = err_q;
    tmo_d   = '0;
    regs_d  = regs_q;
    pop     = 1'b0;
    push    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!uif.rx_empty) begin
          pop     = 1'b1;
          is_rd_d = (rx_byte == CMD_RD);
          if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
            state_d = GET_ADDR;
          end else begin
            resp_d  = RESP_BAD;
            err_d   = sat_inc(err_q);
            state_d = SEND;
          end
        end
      end

      GET_ADDR: begin
        // A byte present on the expiry cycle is still taken.
        if (!uif.rx_empty) begin
          pop    = 1'b1;
          addr_d = rx_byte[3:0];
          if (is_rd_q) begin
            resp_d  = regs_q[rx_byte[3:0]];
            state_d = SEND;
          end else begin
            state_d = GET_DATA;
          end
        end else if (expired) begin
          err_d   = sat_inc(err_q);
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      GET_DATA: begin
        if (!uif.rx_empty) begin
          pop            = 1'b1;
          regs_d[addr_q] = rx_byte;
          resp_d         = RESP_OK;
          state_d        = SEND;
        end else if (expired) begin
          err_d   = sat_inc(err_q);
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      SEND: begin
        if (!uif.tx_full) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      is_rd_q <= 1'b0;
      addr_q  <= '0;
      resp_q  <= '0;
      err_q   <= '0;
      tmo_q   <= '0;
      regs_q  <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      regs_q  <= regs_d;
    end
  end

  // Pop is gated by reset so the FIFO never loses a byte while the block is held.
  assign uif.rd_uart = pop & ~reset;
  assign uif.wr_uart = push;
  assign uif.w_data  = DBIT'(resp_q);
  assign ctrl_reg    = regs_q[0];
  assign busy        = (state_q != IDLE);
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: FIFO-side driver plus a command-level model
// of the register file, error counter and expected reply stream.
module tb_uart_cmd_responder;
  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ctrl_reg;
  logic [7:0] err_cnt;
  logic       busy;

  always #5 clk = ~clk;

  uart_cmd_responder_if #(.DBIT(8)) uif ();

  uart_cmd_responder #(.DBIT(8), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .uif      (uif),
    .ctrl_reg (ctrl_reg),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         both_cnt = 0;
  bit         gap = 1'b0;
  bit         txfull_v = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] txlog[$];
  logic [7:0] expq[$];
  int         wr_at[$];
  logic [7:0] m_regs[16];
  int         m_err;

  task automatic apply_inputs();
    uif.rx_empty = (rxq.size() == 0) || gap;
    uif.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
    uif.tx_full  = txfull_v;
  endtask

  task automatic tick();
    @(negedge clk);
    if (uif.rd_uart && uif.wr_uart) both_cnt++;
    if (uif.rd_uart && rxq.size() != 0) void'(rxq.pop_front());
    if (uif.wr_uart) begin
      txlog.push_back(uif.w_data);
      wr_at.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    apply_inputs();
  endtask

  task automatic drain(input int budget, output bit ok);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((rxq.size() != 0 || busy) && n < budget);
    ok = !(rxq.size() != 0 || busy);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_err = 0;
    expq.delete();
    txlog.delete();
    wr_at.delete();
  endtask

  // Command-level reference: walk complete commands and derive replies.
  task automatic model_stream(input logic [7:0] b[$]);
    int i;
    logic [7:0] a;
    i = 0;
    while (i < b.size()) begin
      if (b[i] == 8'h57) begin
        a = b[i+1];
        m_regs[a % 16] = b[i+2];
        expq.push_back(8'h4B);
        i += 3;
      end else if (b[i] == 8'h52) begin
        a = b[i+1];
        expq.push_back(m_regs[a % 16]);
        i += 2;
      end else begin
        expq.push_back(8'h3F);
        if (m_err < 255) m_err++;
        i += 1;
      end
    end
  endtask

  task automatic send(input logic [7:0] b[$]);
    foreach (b[i]) rxq.push_back(b[i]);
    model_stream(b);
    apply_inputs();
  endtask

  task automatic clear_logs();
    expq.delete();
    txlog.delete();
    wr_at.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxq.push_back(8'h57);
    apply_inputs();
    #1;
    n_cmp++; if (uif.rd_uart !== 1'b0) begin n_bad++; $display("FAIL reset_rd_uart: got %b want 0", uif.rd_uart); end
    n_cmp++; if (uif.wr_uart !== 1'b0) begin n_bad++; $display("FAIL reset_wr_uart: got %b want 0", uif.wr_uart); end
    n_cmp++; if (uif.w_data !== 8'h00) begin n_bad++; $display("FAIL reset_w_data: got %h want 00", uif.w_data); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ctrl_reg !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl_reg: got %h want 00", ctrl_reg); end
    n_cmp++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
    rxq.delete();
    apply_inputs();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_write_read();
    logic [7:0] q[$];
    bit ok;
    clear_logs();
    q = '{8'h57, 8'h03, 8'hA5, 8'h52, 8'h03};
    send(q);
    drain(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_rd_done: got busy=%b left=%0d want idle", busy, rxq.size()); end
    n_cmp++; if (txlog.size() != expq.size()) begin n_bad++; $display("FAIL wr_rd_count: got %0d want %0d", txlog.size(), expq.size()); end
    for (int i = 0; i < txlog.size() && i < expq.size(); i++) begin
      n_cmp++; if (txlog[i] !== expq[i]) begin n_bad++; $display("FAIL wr_rd_reply[%0d]: got %h want %h", i, txlog[i], expq[i]); end
    end
  endtask

  task automatic test_high_addr();
    logic [7:0] q[$];
    bit ok;
    clear_logs();
    q = '{8'h57, 8'h10, 8'h5C};
    send(q);
    drain(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL hiaddr_done: got busy=%b want idle", busy); end
    n_cmp++; if (ctrl_reg !== m_regs[0]) begin n_bad++; $display("FAIL hiaddr_ctrl_reg: got %h want %h", ctrl_reg, m_regs[0]); end
    n_cmp++; if (txlog.size() != 1 || txlog[0] !== expq[0]) begin n_bad++; $display("FAIL hiaddr_reply: got n=%0d want %h", txlog.size(), expq[0]); end
  endtask

  task automatic test_unknown();
    logic [7:0] q[$];
    clear_logs();
    q = '{8'h41};
    send(q);
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL unk_busy1: got %b want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL unk_idle2: got %b want 0", busy); end
    n_cmp++; if (txlog.size() != 1 || txlog[0] !== expq[0]) begin n_bad++; $display("FAIL unk_reply: got n=%0d want %h", txlog.size(), expq[0]); end
    n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL unk_err_cnt: got %0d want %0d", err_cnt, m_err); end
  endtask

  task automatic test_timeout();
    logic [7:0] q[$];
    bit ok;
    clear_logs();
    q = '{8'h57, 8'h02, 8'h33};
    send(q);
    drain(100, ok);
    clear_logs();
    rxq.push_back(8'h57);
    rxq.push_back(8'h02);
    apply_inputs();
    tick();
    tick();
    repeat (TMO - 1) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL tmo_early: got busy=%b want 1", busy); end
    tick();
    if (m_err < 255) m_err++;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_expire: got busy=%b want 0", busy); end
    n_cmp++; if (txlog.size() != 0) begin n_bad++; $display("FAIL tmo_no_reply: got %0d replies want 0", txlog.size()); end
    n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL tmo_err_cnt: got %0d want %0d", err_cnt, m_err); end
    q = '{8'h52, 8'h02};
    send(q);
    drain(100, ok);
    n_cmp++; if (txlog.size() != 1 || txlog[0] !== expq[0]) begin n_bad++; $display("FAIL tmo_reg_kept: got n=%0d want %h", txlog.size(), expq[0]); end
  endtask

  task automatic test_timeout_race();
    logic [7:0] q[$];
    bit ok;
    clear_logs();
    rxq.push_back(8'h57);
    rxq.push_back(8'h06);
    apply_inputs();
    tick();
    tick();
    repeat (TMO - 1) tick();
    q = '{8'h57, 8'h06, 8'h9C};
    model_stream(q);
    rxq.push_back(8'h9C);
    apply_inputs();
    tick();
    tick();
    n_cmp++; if (txlog.size() != 1 || txlog[0] !== 8'h4B) begin n_bad++; $display("FAIL race_reply: got n=%0d want 4b", txlog.size()); end
    n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL race_err_cnt: got %0d want %0d", err_cnt, m_err); end
    clear_logs();
    q = '{8'h52, 8'h06};
    send(q);
    drain(100, ok);
    n_cmp++; if (txlog.size() != 1 || txlog[0] !== expq[0]) begin n_bad++; $display("FAIL race_readback: got n=%0d want %h", txlog.size(), expq[0]); end
  endtask

  task automatic test_backpressure();
    logic [7:0] q[$];
    clear_logs();
    txfull_v = 1'b1;
    q = '{8'h52, 8'h03};
    send(q);
    tick();
    tick();
    repeat (50) tick();
    n_cmp++; if (txlog.size() != 0) begin n_bad++; $display("FAIL bp_held: got %0d pushes want 0", txlog.size()); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy: got %b want 1", busy); end
    n_cmp++; if (uif.w_data !== expq[0]) begin n_bad++; $display("FAIL bp_w_data: got %h want %h", uif.w_data, expq[0]); end
    n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL bp_no_timeout: got %0d want %0d", err_cnt, m_err); end
    txfull_v = 1'b0;
    apply_inputs();
    tick();
    n_cmp++; if (txlog.size() != 1 || txlog[0] !== expq[0]) begin n_bad++; $display("FAIL bp_push: got n=%0d want one %h", txlog.size(), expq[0]); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int base;
    int cum[4];
    bit ok;
    clear_logs();
    both_cnt = 0;
    // Each command costs its byte count plus one push cycle.
    cum = '{4, 7, 9, 13};
    base = cyc;
    q = '{8'h57, 8'h01, 8'h11, 8'h52, 8'h01, 8'h00, 8'h57, 8'h0F, 8'hF0};
    send(q);
    drain(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_done: got busy=%b want idle", busy); end
    n_cmp++; if (wr_at.size() != 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", wr_at.size()); end
    for (int i = 0; i < 4 && i < wr_at.size(); i++) begin
      n_cmp++; if (wr_at[i] != base + cum[i] - 1) begin n_bad++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, wr_at[i] - base, cum[i] - 1); end
      n_cmp++; if (txlog[i] !== expq[i]) begin n_bad++; $display("FAIL b2b_reply[%0d]: got %h want %h", i, txlog[i], expq[i]); end
    end
    n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL b2b_pop_in_send: got %0d want 0", both_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] b;
    int k;
    int n;
    bit ok;
    clear_logs();
    both_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      k = $urandom_range(0, 2);
      if (k == 0) begin
        q.push_back(8'h57); q.push_back(8'($urandom)); q.push_back(8'($urandom));
      end else if (k == 1) begin
        q.push_back(8'h52); q.push_back(8'($urandom));
      end else begin
        do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
        q.push_back(b);
      end
    end
    for (int r = 0; r < 16; r++) begin
      q.push_back(8'h52); q.push_back(8'(r + 16 * $urandom_range(0, 15)));
    end
    send(q);
    n = 0;
    while ((rxq.size() != 0 || busy) && n < 2000) begin
      gap      = ($urandom_range(0, 3) == 0);
      txfull_v = ($urandom_range(0, 2) == 0);
      tick();
      n++;
    end
    gap = 1'b0;
    txfull_v = 1'b0;
    apply_inputs();
    drain(200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_done: got busy=%b left=%0d want idle", busy, rxq.size()); end
    n_cmp++; if (txlog.size() != expq.size()) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", txlog.size(), expq.size()); end
    for (int i = 0; i < txlog.size() && i < expq.size(); i++) begin
      n_cmp++; if (txlog[i] !== expq[i]) begin n_bad++; $display("FAIL rnd_reply[%0d]: got %h want %h", i, txlog[i], expq[i]); end
    end
    n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL rnd_err_cnt: got %0d want %0d", err_cnt, m_err); end
    n_cmp++; if (ctrl_reg !== m_regs[0]) begin n_bad++; $display("FAIL rnd_ctrl_reg: got %h want %h", ctrl_reg, m_regs[0]); end
    n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL rnd_pop_in_send: got %0d want 0", both_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    bit ok;
    clear_logs();
    q = '{8'h57, 8'h05, 8'h11, 8'h57, 8'h00, 8'h5A};
    send(q);
    drain(100, ok);
    rxq.push_back(8'h57);
    rxq.push_back(8'h05);
    apply_inputs();
    tick();
    tick();
    rxq.push_back(8'hEE);
    apply_inputs();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (uif.rd_uart !== 1'b0) begin n_bad++; $display("FAIL rmid_rd_uart: got %b want 0", uif.rd_uart); end
    n_cmp++; if (uif.wr_uart !== 1'b0) begin n_bad++; $display("FAIL rmid_wr_uart: got %b want 0", uif.wr_uart); end
    n_cmp++; if (uif.w_data !== 8'h00) begin n_bad++; $display("FAIL rmid_w_data: got %h want 00", uif.w_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (ctrl_reg !== 8'h00) begin n_bad++; $display("FAIL rmid_ctrl_reg: got %h want 00", ctrl_reg); end
    n_cmp++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL rmid_err_cnt: got %h want 00", err_cnt); end
    rxq.delete();
    apply_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    q = '{8'h52, 8'h05};
    send(q);
    drain(100, ok);
    n_cmp++; if (txlog.size() != 1 || txlog[0] !== expq[0]) begin n_bad++; $display("FAIL rmid_readback: got n=%0d want %h", txlog.size(), expq[0]); end
  endtask

  task automatic test_err_saturate();
    logic [7:0] q[$];
    int bad;
    bit ok;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 260; i++) q.push_back(8'h41);
    send(q);
    drain(1200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sat_done: got busy=%b left=%0d want idle", busy, rxq.size()); end
    n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL sat_err_cnt: got %0d want %0d", err_cnt, m_err); end
    n_cmp++; if (txlog.size() != expq.size()) begin n_bad++; $display("FAIL sat_count: got %0d want %0d", txlog.size(), expq.size()); end
    bad = 0;
    for (int i = 0; i < txlog.size() && i < expq.size(); i++) if (txlog[i] !== expq[i]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL sat_replies: got %0d wrong replies want 0", bad); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_high_addr();
    test_unknown();
    test_timeout();
    test_timeout_race();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_err_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
